// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Prefetch unit in front of the fetch stage. Issues sequential word fetches
//   to instruction memory, buffers the in-order responses in a DEPTH-entry
//   FIFO and presents instruction/PC pairs to fetch. A flush (branch redirect)
//   clears the queue, marks every in-flight response as stale and restarts
//   fetching at the target.
//
//   Optional feature macro: PREFETCH_BYPASS_EN
//     defined   : a live response arriving while the queue is empty is
//                 presented combinationally in the same cycle (0-cycle latency)
//     undefined : every response passes through the FIFO (1-cycle latency)
//
//   Ports
//     clk_i            clock, rising edge
//     rst_i            asynchronous reset, active low
//     mem_req_valid_o  fetch request valid
//     mem_req_ready_i  memory accepts request
//     mem_req_addr_o   word-aligned fetch address
//     mem_rsp_valid_i  in-order response valid (no backpressure)
//     mem_rsp_data_i   fetched instruction word
//     instr_valid_o    instr_o / instr_pc_o valid
//     instr_ready_i    fetch stage consumes head
//     instr_o          instruction at head of queue
//     instr_pc_o       address of instr_o
//     flush_i          redirect request
//     flush_addr_i     redirect target (bits [1:0] ignored)
module instr_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_req_addr_o,
   input  logic        mem_rsp_valid_i,
   input  logic [31:0] mem_rsp_data_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        flush_i,
   input  logic [31:0] flush_addr_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t           state;
   logic [31:0]      fetch_pc;
   logic [31:0]      rsp_pc;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      pc_q   [DEPTH];

   logic [CNT_W:0]   in_use;
   logic [CNT_W-1:0] out_next;
   logic [31:0]      target;
   logic             head_valid;
   logic             fifo_pop;
   logic             req_fire;
   logic             rsp_live;
   logic             rsp_stale;
   logic             push;
`ifdef PREFETCH_BYPASS_EN
   logic             bypass;
`endif

   always_comb begin
      head_valid = (count != '0);
      fifo_pop   = head_valid && instr_ready_i;
      rsp_stale  = mem_rsp_valid_i && (state == DRAIN);
      rsp_live   = mem_rsp_valid_i && (state == RUN);
      // A pop this cycle frees its credit immediately, so a full queue being
      // drained keeps the request channel busy without a bubble.
      in_use          = {1'b0, count} + {1'b0, outstanding} - (CNT_W+1)'(fifo_pop);
      mem_req_valid_o = rst_i && !flush_i && (in_use < (CNT_W+1)'(DEPTH));
      mem_req_addr_o  = fetch_pc;
      req_fire        = mem_req_valid_o && mem_req_ready_i;
      // outstanding counts stale and live requests alike; on a flush every one
      // of them becomes stale, which makes the new drop count simply out_next.
      out_next = outstanding + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid_i);
      target   = flush_addr_i & 32'hFFFF_FFFC;
`ifdef PREFETCH_BYPASS_EN
      bypass        = rsp_live && !head_valid && !flush_i;
      push          = rsp_live && !(bypass && instr_ready_i);
      instr_valid_o = head_valid || bypass;
      instr_o       = bypass ? mem_rsp_data_i : data_q[rd_ptr];
      instr_pc_o    = bypass ? rsp_pc : pc_q[rd_ptr];
`else
      push          = rsp_live;
      instr_valid_o = head_valid;
      instr_o       = data_q[rd_ptr];
      instr_pc_o    = pc_q[rd_ptr];
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         outstanding <= out_next;
         if (flush_i) begin
            fetch_pc <= target;
            rsp_pc   <= target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop_cnt <= out_next;
            state    <= (out_next != '0) ? DRAIN : RUN;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_live) rsp_pc <= rsp_pc + 32'd4;
            if (rsp_stale) begin
               drop_cnt <= drop_cnt - CNT_W'(1);
               if (drop_cnt == CNT_W'(1)) state <= RUN;
            end
            if (push) begin
               data_q[wr_ptr] <= mem_rsp_data_i;
               pc_q[wr_ptr]   <= rsp_pc;
               wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue
//   Directed bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0). A small
//   in-order memory model answers each accepted request after a programmable
//   latency with data = addr ^ 32'h5A5A_A5A5; every accepted request and every
//   consumed instruction is checked against the sequential address expected
//   since the last reset or flush.
module tb_instr_prefetch_queue;

   logic        clk;
   logic        rst_i;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        flush_i;
   logic [31:0] flush_addr_i;

   instr_prefetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_data_i  (mem_rsp_data_i),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .flush_i         (flush_i),
      .flush_addr_i    (flush_addr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned n_acc = 0;
   int unsigned n_pop = 0;
   int unsigned cyc_n = 0;
   int unsigned lat = 1;
   logic [31:0] exp_req = 32'h0;
   logic [31:0] exp_pop = 32'h0;
   logic [31:0] pend_addr [$];
   int unsigned pend_due [$];

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: score the handshakes of the current cycle, cross the
   // edge, then let the memory model drive this cycle's response.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = mem_req_valid_o && mem_req_ready_i;
      a   = mem_req_addr_o;
      if (flush_i) begin
         check("flush_req_valid", 32'(mem_req_valid_o), 32'h0);
         exp_req = flush_addr_i & 32'hFFFF_FFFC;
         exp_pop = flush_addr_i & 32'hFFFF_FFFC;
         n_pop   = 0;
      end else begin
         if (acc) begin
            check("req_addr", a, exp_req);
            exp_req += 32'd4;
            n_acc++;
         end
         if (instr_valid_o && instr_ready_i) begin
            check("pop_pc", instr_pc_o, exp_pop);
            check("pop_data", instr_o, mdata(exp_pop));
            exp_pop += 32'd4;
            n_pop++;
         end
      end
      @(posedge clk);
      #1;
      cyc_n++;
      if (acc) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc_n + lat - 1);
      end
      if (pend_due.size() != 0 && pend_due[0] <= cyc_n) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = mdata(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         mem_rsp_valid_i = 1'b0;
         mem_rsp_data_i  = '0;
      end
      #1;
   endtask

   task automatic wait_pops(input int unsigned n, input string tag);
      int unsigned k = 0;
      while (n_pop < n && k < 40) begin
         tick();
         k++;
      end
      check(tag, 32'(n_pop >= n), 32'h1);
   endtask

   task automatic drain();
      int unsigned k = 0;
      mem_req_ready_i = 1'b0;
      instr_ready_i   = 1'b1;
      flush_i         = 1'b0;
      #1;
      while ((pend_addr.size() != 0 || mem_rsp_valid_i || instr_valid_o) && k < 40) begin
         tick();
         k++;
      end
      check("drain_done", 32'(pend_addr.size() == 0 && !mem_rsp_valid_i && !instr_valid_o), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i           = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      instr_ready_i   = 1'b0;
      flush_i         = 1'b0;
      flush_addr_i    = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_req_valid", 32'(mem_req_valid_o), 32'h0);
      check("rst_req_addr", mem_req_addr_o, 32'h0);
      check("rst_instr_valid", 32'(instr_valid_o), 32'h0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_instr_pc", instr_pc_o, 32'h0);

      // Streaming with 1-cycle memory and an always-ready core
      rst_i           = 1'b1;
      mem_req_ready_i = 1'b1;
      instr_ready_i   = 1'b1;
      #1;
      check("c0_req_valid", 32'(mem_req_valid_o), 32'h1);
      check("c0_req_addr", mem_req_addr_o, 32'h0);
      tick();
`ifdef PREFETCH_BYPASS_EN
      check("c1_instr_valid", 32'(instr_valid_o), 32'h1);
`else
      check("c1_instr_valid", 32'(instr_valid_o), 32'h0);
`endif
      tick();
      check("c2_instr_valid", 32'(instr_valid_o), 32'h1);
      repeat (8) tick();
      check("stream_pops", 32'(n_pop >= 8), 32'h1);

      // Asynchronous reset in the middle of the stream
      rst_i = 1'b0;
      #1;
      check("mid_rst_req_valid", 32'(mem_req_valid_o), 32'h0);
      check("mid_rst_req_addr", mem_req_addr_o, 32'h0);
      check("mid_rst_instr_valid", 32'(instr_valid_o), 32'h0);
      check("mid_rst_instr_pc", instr_pc_o, 32'h0);
      pend_addr.delete();
      pend_due.delete();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      exp_req = 32'h0;
      exp_pop = 32'h0;
      n_acc   = 0;
      n_pop   = 0;
      instr_ready_i   = 1'b0;
      mem_req_ready_i = 1'b1;
      @(posedge clk);
      #2;
      rst_i = 1'b1;
      #1;

      // Core stalled: credits limit issue to DEPTH requests
      repeat (8) tick();
      check("stall_req_count", n_acc, 32'd4);
      check("stall_req_valid", 32'(mem_req_valid_o), 32'h0);
      check("stall_instr_valid", 32'(instr_valid_o), 32'h1);
      check("stall_head_pc", instr_pc_o, 32'h0);
      check("stall_head_data", instr_o, mdata(32'h0));
      instr_ready_i = 1'b1;
      #1;
      check("resume_req_valid", 32'(mem_req_valid_o), 32'h1);
      check("resume_req_addr", mem_req_addr_o, 32'h10);
      for (int i = 0; i < 4; i++) begin
         check("drain4_valid", 32'(instr_valid_o), 32'h1);
         tick();
      end
      check("drain4_pops", n_pop, 32'd4);

      // Memory not ready: request held stable
      mem_req_ready_i = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hold_req_valid", 32'(mem_req_valid_o), 32'h1);
         check("hold_req_addr", mem_req_addr_o, exp_req);
         tick();
      end

      // Flush with 3 in flight, 3-cycle memory latency
      drain();
      lat = 3;
      mem_req_ready_i = 1'b1;
      #1;
      repeat (3) tick();
      flush_i      = 1'b1;
      flush_addr_i = 32'h0000_0103;
      #1;
      check("flush1_req_valid", 32'(mem_req_valid_o), 32'h0);
      tick();
      flush_i = 1'b0;
      #1;
      check("flush1_next_instr_valid", 32'(instr_valid_o), 32'h0);
      check("flush1_next_req_addr", mem_req_addr_o, 32'h100);
      wait_pops(2, "flush1_pops");

      // Second flush while draining stale responses (drop count 2)
      drain();
      lat = 4;
      mem_req_ready_i = 1'b1;
      #1;
      repeat (2) tick();
      flush_i      = 1'b1;
      flush_addr_i = 32'h0000_0180;
      #1;
      tick();
      flush_i = 1'b0;
      #1;
      tick();
      flush_i      = 1'b1;
      flush_addr_i = 32'h0000_0200;
      #1;
      tick();
      flush_i = 1'b0;
      #1;
      check("flush2_next_instr_valid", 32'(instr_valid_o), 32'h0);
      wait_pops(2, "flush2_pops");

      // Address wrap at the top of the address space
      drain();
      lat = 1;
      mem_req_ready_i = 1'b1;
      flush_i      = 1'b1;
      flush_addr_i = 32'hFFFF_FFF8;
      #1;
      tick();
      flush_i = 1'b0;
      #1;
      check("wrap_addr0", mem_req_addr_o, 32'hFFFF_FFF8);
      tick();
      check("wrap_addr1", mem_req_addr_o, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr2", mem_req_addr_o, 32'h0000_0000);
      wait_pops(3, "wrap_pops");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
